// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and the parity helper.
// Used by the transmitter and the receiver alike.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam logic START_BIT            = 1'b0;
    localparam logic STOP_BIT             = 1'b1;
    localparam int   DATA_BITS            = 8;
    localparam int   DEFAULT_CLKS_PER_BIT = 40;

    // odd = 0 gives even parity (bit makes the total count of ones even)
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
        return odd ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: counts 0..CLKS_PER_BIT-1 and raises tick (registered) during the
// terminal-count cycle. clear holds the count at zero.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count_q, count_d;
    logic          tick_q, tick_d;

    always_comb begin
        if (clear || count_q == LAST) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(1);
        end
        // Look ahead one cycle so tick is a flop aligned with count_q == LAST
        tick_d = (count_d == LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, stop bit.
// Define UART_TX_PARITY_EN to include the parity bit (11-bit frames); otherwise 10-bit frames.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 load,
    input  logic                 parity_odd,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int            BW       = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 tick;
    logic                 accept;
    logic                 baud_clear;

`ifndef UART_TX_PARITY_EN
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    // The done cycle also accepts, so back-to-back frames have no idle gap
    assign done       = (state_q == STOP) && tick;
    assign accept     = load && (!busy_q || done);
    assign baud_clear = (state_q == IDLE) || accept;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .reset(reset),
        .clear(baud_clear),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        busy_d    = busy_q;

        if (accept) begin
            state_d   = START;
            shift_d   = data_in;
            bit_cnt_d = '0;
            busy_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_d  = parity_bit(data_in, parity_odd);
`else
            parity_d  = 1'b0;
`endif
        end else if (tick) begin
            case (state_q)
                START: state_d = DATA;
                DATA: begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
                PARITY: state_d = STOP;
                STOP: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end

        // tx is decoded from the next state so the line itself comes straight off a flop
        case (state_d)
            START:   tx_d = START_BIT;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = STOP_BIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed self-checking bench for uart_transmitter (CLKS_PER_BIT = 40).
// Frame length follows UART_TX_PARITY_EN.
module tb_uart_transmitter;

    localparam int C = 40;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * C;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       load;
    logic       parity_odd;
    logic       tx;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_transmitter #(
        .CLKS_PER_BIT(C)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .load      (load),
        .parity_odd(parity_odd),
        .tx        (tx),
        .busy      (busy),
        .done      (done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bit i of the result is the line level during bit window i of the frame
    function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic podd);
        logic p;
        p = podd ? ~^b : ^b;
`ifdef UART_TX_PARITY_EN
        return {1'b1, p, b, 1'b0};
`else
        return {1'b0, 1'b1, b, 1'b0};
`endif
    endfunction

    task automatic start_frame(input logic [7:0] b, input logic podd);
        @(negedge clk);
        data_in    = b;
        parity_odd = podd;
        load       = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    // Called just after the accepting edge; checks {tx,busy,done} for every cycle of the frame.
    // mid_k > 0 pulses load for one cycle with noise on data_in at that frame cycle.
    task automatic check_frame(input logic [7:0] b, input logic podd, input int mid_k,
                               input logic [7:0] noise);
        logic [10:0] fb;
        fb = frame_bits(b, podd);
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            check_val($sformatf("frame %02h cyc %0d", b, k), 32'({tx, busy, done}),
                      32'({fb[(k-1)/C], 1'b1, (k == FRAME)}));
            if (mid_k > 0 && k == mid_k) begin
                load    = 1'b1;
                data_in = noise;
            end else if (mid_k > 0 && k == mid_k + 1) begin
                load = 1'b0;
            end
        end
        $display("frame data=%02h podd=%0b checked over %0d cycles", b, podd, FRAME);
    endtask

    task automatic check_post(input string tag);
        @(negedge clk);
        check_val(tag, 32'({tx, busy, done}), 32'(3'b100));
    endtask

    // Independent mid-bit sampling receiver
    task automatic loopback(input logic [7:0] b, input logic podd);
        logic [10:0] rx;
        int          nd;
        rx = '0;
        nd = 0;
        start_frame(b, podd);
        for (int k = 1; k <= FRAME + 1; k++) begin
            @(negedge clk);
            if ((k - 1) % C == C / 2 && (k - 1) / C < NB) rx[(k-1)/C] = tx;
            if (done) nd++;
        end
        check_val("rx_start", 32'(rx[0]), 32'(1'b0));
        check_val("rx_data", 32'(rx[8:1]), 32'(b));
`ifdef UART_TX_PARITY_EN
        check_val("rx_parity", 32'(rx[9]), 32'(podd ? ~^b : ^b));
`endif
        check_val("rx_stop", 32'(rx[NB-1]), 32'(1'b1));
        check_val("rx_done_count", 32'(nd), 32'(1));
        $display("loopback data=%02h podd=%0b rx=%02h dones=%0d", b, podd, rx[8:1], nd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        logic [7:0] lb_bytes [4];
        lb_bytes = '{8'h00, 8'h55, 8'hAA, 8'h80};

        reset      = 1'b1;
        load       = 1'b0;
        data_in    = 8'h00;
        parity_odd = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_state", 32'({tx, busy, done}), 32'(3'b100));
        reset = 1'b0;

        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if ({tx, busy, done} !== 3'b100) bad++;
        end
        check_val("idle_500_bad_cycles", 32'(bad), 32'(0));
        $display("idle 500 cycles bad=%0d", bad);

        start_frame(8'h0C, 1'b0);
        check_frame(8'h0C, 1'b0, 0, 8'h00);
        check_post("post_0C");

        // Back-to-back: load held through done, next byte already on data_in
        @(negedge clk);
        data_in    = 8'h07;
        parity_odd = 1'b1;
        load       = 1'b1;
        @(posedge clk);
        #1;
        data_in = 8'h45;
        check_frame(8'h07, 1'b1, 0, 8'h00);
        @(posedge clk);
        #1;
        load = 1'b0;
        check_frame(8'h45, 1'b1, 0, 8'h00);
        check_post("post_45");

        // Reset in cycle 200 of an 0xFF frame
        start_frame(8'hFF, 1'b0);
        repeat (199) @(negedge clk);
        check_val("ff_busy_before_reset", 32'(busy), 32'(1'b1));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("mid_reset_state", 32'({tx, busy, done}), 32'(3'b100));
        reset = 1'b0;
        bad = 0;
        repeat (FRAME) begin
            @(negedge clk);
            if ({tx, busy, done} !== 3'b100) bad++;
        end
        check_val("after_reset_idle_bad", 32'(bad), 32'(0));
        $display("mid-frame reset abandoned frame, idle bad=%0d", bad);
        start_frame(8'h3C, 1'b1);
        check_frame(8'h3C, 1'b1, 0, 8'h00);
        check_post("post_3C");

        // Loads during a frame are ignored
        start_frame(8'h96, 1'b0);
        check_frame(8'h96, 1'b0, 100, 8'h5A);
        check_post("post_96");
        start_frame(8'hC3, 1'b1);
        check_frame(8'hC3, 1'b1, FRAME - C, 8'h11);
        check_post("post_C3");

        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 4; i++) begin
                loopback(lb_bytes[i], m[0]);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
